// File: rtl/memory_access.sv
// Memory stage: one outstanding load/store on a simple req/ack bus.
// Non-memory ops and misaligned accesses complete in one cycle without using the bus.
module memory_access #(
   parameter int XLEN     = 32,
   parameter int OP_WIDTH = 11,
   parameter int OP_LOAD  = 3,
   parameter int OP_STORE = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                E_valid_i,
   output logic                M_ready_o,
   input  logic [OP_WIDTH-1:0] F_epcode_i,
   input  logic [2:0]          F_funct3_i,
   input  logic [XLEN-1:0]     E_valE_i,
   input  logic [XLEN-1:0]     D_rs2_data_i,
   input  logic [4:0]          D_rd_i,
   input  logic                D_rd_we_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [XLEN-1:0]     mem_addr_o,
   output logic [3:0]          mem_wstrb_o,
   output logic [XLEN-1:0]     mem_wdata_o,
   input  logic                mem_ack_i,
   input  logic [XLEN-1:0]     mem_rdata_i,
   output logic                M_valid_o,
   output logic [XLEN-1:0]     M_valE_o,
   output logic [XLEN-1:0]     M_valM_o,
   output logic [4:0]          M_rd_o,
   output logic                M_rd_we_o,
   output logic                M_misalign_o
);

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;

   logic            accept, is_load, is_store, is_mem, is_half, is_word, misalign, start;
   logic [1:0]      off;
   logic [3:0]      st_wstrb;
   logic [XLEN-1:0] st_wdata, lane_word, load_data;
   logic            cap_load, cap_rd_we;
   logic [2:0]      cap_f3;
   logic [1:0]      cap_off;
   logic [4:0]      cap_rd;
   logic [XLEN-1:0] cap_valE;
   logic            unused_op;

   assign unused_op = ^F_epcode_i;
   assign off       = E_valE_i[1:0];
   assign M_ready_o = (state == IDLE);
   assign mem_req_o = (state == BUSY);
   assign accept    = E_valid_i & M_ready_o;
   // load wins when both opcode bits are set
   assign is_load   = F_epcode_i[OP_LOAD];
   assign is_store  = F_epcode_i[OP_STORE] & ~is_load;
   assign is_mem    = is_load | is_store;

   always_comb begin
      is_half = 1'b0;
      is_word = 1'b0;
      if (is_load) begin
         case (F_funct3_i)
            3'b000, 3'b100: is_half = 1'b0;
            3'b001, 3'b101: is_half = 1'b1;
            default:        is_word = 1'b1;
         endcase
      end else begin
         case (F_funct3_i)
            3'b000:  is_half = 1'b0;
            3'b001:  is_half = 1'b1;
            default: is_word = 1'b1;
         endcase
      end
   end

   assign misalign = (is_half & off[0]) | (is_word & (off != 2'b00));
   assign start    = accept & is_mem & ~misalign;

   always_comb begin
      st_wstrb = 4'b1111;
      st_wdata = D_rs2_data_i;
      case (F_funct3_i)
         3'b000: begin
            st_wstrb = 4'b0001 << off;
            st_wdata = {4{D_rs2_data_i[7:0]}};
         end
         3'b001: begin
            st_wstrb = 4'b0011 << off;
            st_wdata = {2{D_rs2_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = BUSY;
         BUSY:    if (mem_ack_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // bus request fields are launched once and held for the whole BUSY phase
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_addr_o  <= '0;
         mem_we_o    <= 1'b0;
         mem_wstrb_o <= 4'b0000;
         mem_wdata_o <= '0;
         cap_load    <= 1'b0;
         cap_f3      <= 3'b000;
         cap_off     <= 2'b00;
         cap_rd      <= 5'd0;
         cap_rd_we   <= 1'b0;
         cap_valE    <= '0;
      end else if (start) begin
         mem_addr_o  <= {E_valE_i[XLEN-1:2], 2'b00};
         mem_we_o    <= is_store;
         mem_wstrb_o <= is_store ? st_wstrb : 4'b0000;
         mem_wdata_o <= is_store ? st_wdata : '0;
         cap_load    <= is_load;
         cap_f3      <= F_funct3_i;
         cap_off     <= off;
         cap_rd      <= D_rd_i;
         cap_rd_we   <= D_rd_we_i;
         cap_valE    <= E_valE_i;
      end
   end

   assign lane_word = mem_rdata_i >> {cap_off, 3'b000};

   always_comb begin
      load_data = mem_rdata_i;
      case (cap_f3)
         3'b000:  load_data = {{(XLEN-8){lane_word[7]}}, lane_word[7:0]};
         3'b001:  load_data = {{(XLEN-16){lane_word[15]}}, lane_word[15:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_word[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_word[15:0]};
         default: load_data = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         M_valid_o    <= 1'b0;
         M_valE_o     <= '0;
         M_valM_o     <= '0;
         M_rd_o       <= 5'd0;
         M_rd_we_o    <= 1'b0;
         M_misalign_o <= 1'b0;
      end else begin
         M_valid_o <= 1'b0;
         M_rd_we_o <= 1'b0;
         if (state == BUSY && mem_ack_i) begin
            M_valid_o    <= 1'b1;
            M_valE_o     <= cap_valE;
            M_valM_o     <= cap_load ? load_data : '0;
            M_rd_o       <= cap_rd;
            M_rd_we_o    <= cap_load & cap_rd_we;
            M_misalign_o <= 1'b0;
         end else if (accept && (!is_mem || misalign)) begin
            M_valid_o    <= 1'b1;
            M_valE_o     <= E_valE_i;
            M_valM_o     <= '0;
            M_rd_o       <= D_rd_i;
            M_rd_we_o    <= ~is_mem & D_rd_we_i;
            M_misalign_o <= is_mem;
         end
      end
   end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port E_valid_i, input, 1, upstream instruction valid.
REQ-005 SHALL have port M_ready_o, input-side handshake, output, 1, stage can accept.
REQ-006 SHALL have port F_epcode_i, input, OP_WIDTH, one-hot opcode; uses bits op_load and op_store from define.v.
REQ-007 SHALL have port F_funct3_i, input, 3, access size and sign.
REQ-008 SHALL have port E_valE_i, input, XLEN, ALU result, used as the memory address.
REQ-009 SHALL have port D_rs2_data_i, input, XLEN, store data.
REQ-010 SHALL have ports D_rd_i (input, 5) and D_rd_we_i (input, 1), destination register and write enable.
REQ-011 SHALL have port mem_req_o, output, 1, bus request.
REQ-012 SHALL have port mem_we_o, output, 1, write when 1.
REQ-013 SHALL have ports mem_addr_o (output, XLEN, word-aligned: addr[1:0] forced to 0), mem_wstrb_o (output, 4, byte lanes) and mem_wdata_o (output, XLEN).
REQ-014 SHALL have ports mem_ack_i (input, 1, transfer complete) and mem_rdata_i (input, XLEN, read word valid with ack).
REQ-015 SHALL have output M_valid_o (1) plus outputs M_valE_o, M_valM_o (XLEN), M_rd_o (5), M_rd_we_o (1) and M_misalign_o (1).

Function
REQ-016 SHALL accept an instruction in a cycle where E_valid_i and M_ready_o are both 1; M_ready_o = (state == IDLE), combinational.
REQ-017 SHALL use FSM states IDLE and BUSY: IDLE->BUSY on accepting an aligned load/store; BUSY->IDLE on the edge where mem_ack_i = 1; otherwise hold.
REQ-018 SHALL treat an accept with neither op_load nor op_store as a non-memory op: in the next cycle M_valid_o=1, M_valE_o=E_valE_i, M_valM_o=0, M_rd_o/M_rd_we_o as captured; throughput is 1 per cycle.
REQ-019 SHALL treat an accept with both op_load and op_store set as a load.
REQ-020 SHALL, while in BUSY, drive mem_req_o=1 and hold mem_addr_o, mem_we_o, mem_wstrb_o and mem_wdata_o stable until ack; ack may arrive in the first BUSY cycle.
REQ-021 SHALL drive mem_req_o=0 in IDLE and ignore mem_ack_i in IDLE.
REQ-022 SHALL, in the cycle after ack, assert M_valid_o=1 for exactly one cycle; the next instruction may be accepted in that same cycle.
REQ-023 SHALL decode stores as follows, with wdata lane replication: SB (funct3 000) gives wstrb=0001<<addr[1:0] and byte replicated x4; SH (001) gives wstrb=0011<<addr[1:0] and half replicated x2; SW (010) gives wstrb=1111. Other funct3 values SHALL be treated as SW.
REQ-024 SHALL decode loads by selecting the lane from rdata by addr[1:0]: LB (000) and LH (001) sign-extend; LW (010) passes the word; LBU (100) and LHU (101) zero-extend. Other funct3 values SHALL be treated as LW. The result is registered into M_valM_o.
REQ-025 SHALL define misalignment as a halfword with addr[0]=1 or a word with addr[1:0]!=0. A misaligned access SHALL issue no bus request, stay in IDLE, and give next cycle M_valid_o=1, M_misalign_o=1, M_valM_o=0, M_rd_we_o=0.
REQ-026 SHALL drive M_rd_we_o=0 for stores, and whenever M_valid_o=0.
REQ-027 SHALL, in every cycle without a completion, drive M_valid_o=0; the other M_* outputs then hold their last values.
REQ-028 SHALL pass mem_we_o=1 only for stores; load mem_wstrb_o=0000.

Reset
REQ-029 SHALL, while rst_n_i=0, immediately force state=IDLE, mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0, M_valid_o=0, M_valE_o=0, M_valM_o=0, M_rd_o=0, M_rd_we_o=0, M_misalign_o=0; M_ready_o=1.
REQ-030 SHALL abandon an in-flight transfer on reset; an ack arriving after reset release is ignored.

Verification
REQ-031 SHALL be verified with back-to-back ALU ops E_valE_i=5,6,7 on 3 cycles -> M_valid_o high for 3 consecutive cycles with M_valE_o=5,6,7 and M_ready_o constantly 1.
REQ-032 SHALL be verified with LB at addr 0x1003, rdata=0x80FF_0000 with ack after 2 BUSY cycles -> mem_addr_o=0x1000, M_ready_o=0 for 2 cycles, then M_valM_o=0xFFFF_FF80 with M_valid_o pulsed once.
REQ-033 SHALL be verified with SH at addr 0x2002, rs2=0x1234_ABCD and ack in the first BUSY cycle -> mem_we_o=1, wstrb=1100, wdata=0xABCD_ABCD; M_rd_we_o=0.
REQ-034 SHALL be verified with LW at addr 0x3001 -> mem_req_o never asserted; next cycle M_misalign_o=1, M_valid_o=1, M_rd_we_o=0.
REQ-035 SHALL be verified with LHU at addr 0x4002, rdata=0x8001_0000 -> M_valM_o=0x0000_8001.
REQ-036 SHALL be verified with rst_n_i low during BUSY followed by a late ack -> mem_req_o drops without waiting for a clock, M_valid_o stays 0, and M_ready_o=1.
